// File: rtl/ps2_keyb_rx.sv
// ps2_keyb_rx -- PS/2 keyboard receiver.
//
// Samples the raw PS/2 clock/data lines, removes clock glitches, deframes
// 11-bit frames (start, 8 data LSB-first, odd parity, stop), and publishes
// accepted scan codes to the CPU-visible keyb_char word.
//
// Parameters:
//   FILTER_LEN      consecutive equal ps2_clk samples needed to change the
//                   filtered clock level (min 2)
//   TIMEOUT_CYCLES  idle clocks mid-frame before the frame is aborted
//
// Ports:
//   clock       system clock, all state on posedge
//   reset_n     asynchronous active-low reset
//   ps2_clk     raw PS/2 clock line (asynchronous)
//   ps2_data    raw PS/2 data line (asynchronous)
//   keyb_char   32-bit scan-code word read by the CPU
//   byte_valid  one-cycle pulse when a byte is accepted
//   byte_data   last accepted raw byte, held until the next accept
//   frame_err   one-cycle pulse on parity, stop or timeout error
//
// Build option:
//   KEYB_MAKE_BREAK_EN  when defined, keyb_char tracks the currently held key
//                       (E0/F0 prefixes decoded) instead of the last four bytes.
module ps2_keyb_rx #(
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [31:0] keyb_char,
  output logic        byte_valid,
  output logic [7:0]  byte_data,
  output logic        frame_err
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_e;

  logic                  clk_meta_q, clk_sync_q;
  logic                  dat_meta_q, dat_sync_q;
  logic [FILTER_LEN-1:0] flt_q;
  logic [FILTER_LEN-1:0] dat_dly_q;
  logic                  fclk_q;

  state_e                state_q, state_d;
  logic [7:0]            shift_q, shift_d;
  logic [2:0]            bitcnt_q, bitcnt_d;
  logic                  par_q, par_d;
  logic [CNT_W-1:0]      tmo_q, tmo_d;
  logic [31:0]           keyb_q, keyb_d;
  logic [7:0]            byte_data_q;
  logic                  byte_valid_q, frame_err_q;
  logic                  accept, err;

  logic                  fall;
  logic                  sdat;

  // Synchronisers and clock glitch filter. The data line runs through a delay
  // line of the same depth so the sampled bit corresponds to the moment the
  // clock actually fell on the pin.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      clk_meta_q <= 1'b1;
      clk_sync_q <= 1'b1;
      dat_meta_q <= 1'b1;
      dat_sync_q <= 1'b1;
      flt_q      <= '1;
      dat_dly_q  <= '1;
      fclk_q     <= 1'b1;
    end else begin
      clk_meta_q <= ps2_clk;
      clk_sync_q <= clk_meta_q;
      dat_meta_q <= ps2_data;
      dat_sync_q <= dat_meta_q;
      flt_q      <= {flt_q[FILTER_LEN-2:0], clk_sync_q};
      dat_dly_q  <= {dat_dly_q[FILTER_LEN-2:0], dat_sync_q};
      if (&flt_q)       fclk_q <= 1'b1;
      else if (~|flt_q) fclk_q <= 1'b0;
    end
  end

  // fall is asserted in the cycle in which fclk_q is about to drop.
  assign fall = fclk_q & ~|flt_q;
  assign sdat = dat_dly_q[FILTER_LEN-1];

  // Frame FSM and timeout.
  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    bitcnt_d = bitcnt_q;
    par_d    = par_q;
    tmo_d    = tmo_q;
    accept   = 1'b0;
    err      = 1'b0;
    if (fall) begin
      tmo_d = '0;
      case (state_q)
        S_IDLE: begin
          if (!sdat) begin
            state_d  = S_DATA;
            bitcnt_d = 3'd0;
          end
        end
        S_DATA: begin
          shift_d  = {sdat, shift_q[7:1]};
          bitcnt_d = bitcnt_q + 3'd1;
          if (bitcnt_q == 3'd7) state_d = S_PARITY;
        end
        S_PARITY: begin
          par_d   = sdat;
          state_d = S_STOP;
        end
        S_STOP: begin
          // Odd parity: data bits plus parity bit must hold an odd number of ones.
          if (sdat && (^{shift_q, par_q})) accept = 1'b1;
          else                             err    = 1'b1;
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end else if (state_q == S_IDLE) begin
      tmo_d = '0;
    end else if (tmo_q == CNT_MAX) begin
      state_d = S_IDLE;
      tmo_d   = '0;
      err     = 1'b1;
    end else begin
      tmo_d = tmo_q + 1'b1;
    end
  end

`ifdef KEYB_MAKE_BREAK_EN
  logic ext_q, ext_d;
  logic rel_q, rel_d;

  // Prefix bytes only arm flags; the following key byte resolves them.
  always_comb begin
    keyb_d = keyb_q;
    ext_d  = ext_q;
    rel_d  = rel_q;
    if (accept) begin
      if (shift_q == 8'hE0) begin
        ext_d = 1'b1;
      end else if (shift_q == 8'hF0) begin
        rel_d = 1'b1;
      end else begin
        keyb_d = rel_q ? 32'h0 : {16'h0, (ext_q ? 8'hE0 : 8'h00), shift_q};
        ext_d  = 1'b0;
        rel_d  = 1'b0;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ext_q <= 1'b0;
      rel_q <= 1'b0;
    end else begin
      ext_q <= ext_d;
      rel_q <= rel_d;
    end
  end
`else
  // Last four accepted bytes, newest in the low byte.
  always_comb begin
    keyb_d = keyb_q;
    if (accept) keyb_d = {keyb_q[23:0], shift_q};
  end
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      shift_q      <= 8'h00;
      bitcnt_q     <= 3'd0;
      par_q        <= 1'b0;
      tmo_q        <= '0;
      keyb_q       <= 32'h0;
      byte_data_q  <= 8'h00;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      bitcnt_q     <= bitcnt_d;
      par_q        <= par_d;
      tmo_q        <= tmo_d;
      keyb_q       <= keyb_d;
      byte_valid_q <= accept;
      frame_err_q  <= err;
      if (accept) byte_data_q <= shift_q;
    end
  end

  assign keyb_char  = keyb_q;
  assign byte_valid = byte_valid_q;
  assign byte_data  = byte_data_q;
  assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_ps2_keyb_rx.sv
// Testbench for ps2_keyb_rx: drives PS/2 frames on the pins and checks the
// strobes and the keyb_char word against a behavioural scan-code model.
module tb_ps2_keyb_rx;
  localparam int FL   = 4;
  localparam int TMO  = 2000;
  localparam int HALF = 15;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        ps2_clk = 1'b1;
  logic        ps2_data = 1'b1;
  logic [31:0] keyb_char;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        frame_err;

  ps2_keyb_rx #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TMO)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .keyb_char (keyb_char),
    .byte_valid(byte_valid),
    .byte_data (byte_data),
    .frame_err (frame_err)
  );

  always #5 clock = ~clock;

  int unsigned cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int nvec = 0;
  int nerr = 0;

  // Strobe monitor
  int bv_hi = 0, bv_rise = 0, fe_hi = 0, fe_rise = 0, both_hi = 0;
  int unsigned bv_cyc = 0, fe_cyc = 0;
  logic bv_prev = 1'b0, fe_prev = 1'b0;
  always @(negedge clock) begin
    if (!reset_n) begin
      bv_prev = 1'b0;
      fe_prev = 1'b0;
    end else begin
      if (byte_valid) bv_hi++;
      if (frame_err) fe_hi++;
      if (byte_valid && !bv_prev) begin bv_rise++; bv_cyc = cyc; end
      if (frame_err && !fe_prev) begin fe_rise++; fe_cyc = cyc; end
      if (byte_valid && frame_err) both_hi++;
      bv_prev = byte_valid;
      fe_prev = frame_err;
    end
  end

  // Reference model of the CPU-visible state
  logic [31:0] m_keyb = 32'h0;
  logic [7:0]  m_bd = 8'h0;
  bit          m_ext = 1'b0, m_rel = 1'b0;

  function automatic void model_reset();
    m_keyb = 32'h0; m_bd = 8'h0; m_ext = 1'b0; m_rel = 1'b0;
  endfunction

  function automatic void model_accept(input logic [7:0] b);
    m_bd = b;
`ifdef KEYB_MAKE_BREAK_EN
    if (b == 8'hE0) m_ext = 1'b1;
    else if (b == 8'hF0) m_rel = 1'b1;
    else begin
      if (m_rel) m_keyb = 32'h0;
      else m_keyb = 32'h0 + (m_ext ? 32'hE000 : 32'h0) + 32'(b);
      m_ext = 1'b0; m_rel = 1'b0;
    end
`else
    m_keyb = (m_keyb << 8) | 32'(b);
`endif
  endfunction

  int unsigned stop_cyc = 0, last_fall_cyc = 0;

  // Drive nbits of an 11-bit frame; optional 2-cycle clock glitch before bit glitch_at.
  task automatic send_frame(input logic [7:0] b, input bit bad_par, input int nbits,
                            input int glitch_at);
    logic [10:0] bits;
    bits = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      @(negedge clock);
      ps2_data = bits[i];
      repeat (HALF/2) @(negedge clock);
      if (i == glitch_at) begin
        ps2_clk = 1'b0;
        repeat (2) @(negedge clock);
        ps2_clk = 1'b1;
      end
      repeat (HALF - HALF/2) @(negedge clock);
      ps2_clk = 1'b0;
      last_fall_cyc = cyc;
      if (i == 10) stop_cyc = cyc;
      repeat (HALF) @(negedge clock);
      ps2_clk = 1'b1;
    end
    repeat (HALF) @(negedge clock);
    ps2_data = 1'b1;
    repeat (HALF) @(negedge clock);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (5) @(negedge clock);
    nvec++; if (keyb_char !== 32'h0) begin nerr++; $display("FAIL reset_keyb: got %h want 00000000", keyb_char); end
    nvec++; if (byte_data !== 8'h0) begin nerr++; $display("FAIL reset_bd: got %h want 00", byte_data); end
    nvec++; if (byte_valid !== 1'b0) begin nerr++; $display("FAIL reset_bv: got %b want 0", byte_valid); end
    nvec++; if (frame_err !== 1'b0) begin nerr++; $display("FAIL reset_fe: got %b want 0", frame_err); end
    reset_n = 1'b1;
    model_reset();
    repeat (10) @(negedge clock);
  endtask

  task automatic test_default_frames();
    logic [7:0] codes [2];
    int bv0, bh0, fe0;
    int unsigned lat;
    codes[0] = 8'h1C; codes[1] = 8'h32;
    for (int k = 0; k < 2; k++) begin
      bv0 = bv_rise; bh0 = bv_hi; fe0 = fe_rise;
      send_frame(codes[k], 1'b0, 11, -1);
      model_accept(codes[k]);
      lat = bv_cyc - stop_cyc;
      nvec++; if (bv_rise - bv0 != 1) begin nerr++; $display("FAIL frame_bv_count: got %0d want 1", bv_rise - bv0); end
      nvec++; if (bv_hi - bh0 != 1) begin nerr++; $display("FAIL frame_bv_width: got %0d want 1", bv_hi - bh0); end
      nvec++; if (fe_rise != fe0) begin nerr++; $display("FAIL frame_no_err: got %0d want 0", fe_rise - fe0); end
      nvec++; if (byte_data !== codes[k]) begin nerr++; $display("FAIL frame_bd: got %h want %h", byte_data, codes[k]); end
      nvec++; if (keyb_char !== m_keyb) begin nerr++; $display("FAIL frame_keyb: got %h want %h", keyb_char, m_keyb); end
      nvec++; if (lat < FL + 2 || lat > FL + 4) begin nerr++; $display("FAIL frame_latency: got %0d want %0d+-1", lat, FL + 3); end
    end
`ifndef KEYB_MAKE_BREAK_EN
    nvec++; if (keyb_char !== 32'h00001C32) begin nerr++; $display("FAIL frame_keyb_hist: got %h want 00001c32", keyb_char); end
`endif
  endtask

  task automatic test_parity_error();
    int bv0, fe0, fh0;
    bv0 = bv_rise; fe0 = fe_rise; fh0 = fe_hi;
    send_frame(8'h1C, 1'b1, 11, -1);
    nvec++; if (fe_rise - fe0 != 1) begin nerr++; $display("FAIL par_err_count: got %0d want 1", fe_rise - fe0); end
    nvec++; if (fe_hi - fh0 != 1) begin nerr++; $display("FAIL par_err_width: got %0d want 1", fe_hi - fh0); end
    nvec++; if (bv_rise != bv0) begin nerr++; $display("FAIL par_no_bv: got %0d want 0", bv_rise - bv0); end
    nvec++; if (keyb_char !== m_keyb) begin nerr++; $display("FAIL par_keyb: got %h want %h", keyb_char, m_keyb); end
    nvec++; if (byte_data !== m_bd) begin nerr++; $display("FAIL par_bd: got %h want %h", byte_data, m_bd); end
  endtask

  task automatic test_timeout();
    int bv0, fe0;
    int unsigned dt;
    bv0 = bv_rise; fe0 = fe_rise;
    send_frame(8'h5A, 1'b0, 5, -1);
    for (int i = 0; i < TMO + 200 && fe_rise == fe0; i++) @(negedge clock);
    dt = fe_cyc - last_fall_cyc;
    nvec++; if (fe_rise - fe0 != 1) begin nerr++; $display("FAIL tmo_err: got %0d want 1", fe_rise - fe0); end
    nvec++; if (dt < FL + 1 + TMO || dt > FL + 5 + TMO) begin nerr++; $display("FAIL tmo_time: got %0d want %0d", dt, FL + 3 + TMO); end
    nvec++; if (bv_rise != bv0) begin nerr++; $display("FAIL tmo_no_bv: got %0d want 0", bv_rise - bv0); end
    nvec++; if (keyb_char !== m_keyb) begin nerr++; $display("FAIL tmo_keyb: got %h want %h", keyb_char, m_keyb); end
    repeat (20) @(negedge clock);
    send_frame(8'h29, 1'b0, 11, -1);
    model_accept(8'h29);
    nvec++; if (bv_rise - bv0 != 1) begin nerr++; $display("FAIL tmo_next_bv: got %0d want 1", bv_rise - bv0); end
    nvec++; if (keyb_char[7:0] !== 8'h29 || keyb_char !== m_keyb) begin nerr++; $display("FAIL tmo_next_keyb: got %h want %h", keyb_char, m_keyb); end
  endtask

  task automatic test_glitch();
    int bv0, fe0;
    bv0 = bv_rise; fe0 = fe_rise;
    @(negedge clock);
    ps2_clk = 1'b0;
    repeat (2) @(negedge clock);
    ps2_clk = 1'b1;
    repeat (30) @(negedge clock);
    nvec++; if (bv_rise != bv0 || fe_rise != fe0) begin nerr++; $display("FAIL glitch_idle: got bv %0d fe %0d want 0 0", bv_rise - bv0, fe_rise - fe0); end
    send_frame(8'h4B, 1'b0, 11, 4);
    model_accept(8'h4B);
    nvec++; if (bv_rise - bv0 != 1 || fe_rise != fe0) begin nerr++; $display("FAIL glitch_frame_strobes: got bv %0d fe %0d want 1 0", bv_rise - bv0, fe_rise - fe0); end
    nvec++; if (byte_data !== 8'h4B) begin nerr++; $display("FAIL glitch_bd: got %h want 4b", byte_data); end
    nvec++; if (keyb_char !== m_keyb) begin nerr++; $display("FAIL glitch_keyb: got %h want %h", keyb_char, m_keyb); end
  endtask

  task automatic test_reset_midframe();
    send_frame(8'h77, 1'b0, 5, -1);
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    nvec++; if (keyb_char !== 32'h0) begin nerr++; $display("FAIL rstmid_keyb: got %h want 00000000", keyb_char); end
    nvec++; if (byte_data !== 8'h0) begin nerr++; $display("FAIL rstmid_bd: got %h want 00", byte_data); end
    nvec++; if (byte_valid !== 1'b0 || frame_err !== 1'b0) begin nerr++; $display("FAIL rstmid_strobes: got %b%b want 00", byte_valid, frame_err); end
    model_reset();
    ps2_clk = 1'b1; ps2_data = 1'b1;
    repeat (4) @(negedge clock);
    reset_n = 1'b1;
    repeat (20) @(negedge clock);
    send_frame(8'h1C, 1'b0, 11, -1);
    model_accept(8'h1C);
    nvec++; if (keyb_char !== 32'h0000001C) begin nerr++; $display("FAIL rstmid_next_keyb: got %h want 0000001c", keyb_char); end
  endtask

  task automatic test_random_frames();
    logic [7:0] b;
    bit bad;
    int bv0, fe0;
    for (int k = 0; k < 30; k++) begin
      b = 8'($urandom_range(0, 255));
      bad = ($urandom_range(0, 3) == 0);
      bv0 = bv_rise; fe0 = fe_rise;
      send_frame(b, bad, 11, -1);
      if (!bad) model_accept(b);
      nvec++; if ((bv_rise - bv0) != (bad ? 0 : 1) || (fe_rise - fe0) != (bad ? 1 : 0)) begin
        nerr++; $display("FAIL rand_strobes[%0d]: got bv %0d fe %0d want bad=%0d", k, bv_rise - bv0, fe_rise - fe0, bad);
      end
      nvec++; if (byte_data !== m_bd || keyb_char !== m_keyb) begin
        nerr++; $display("FAIL rand_out[%0d]: got %h/%h want %h/%h", k, byte_data, keyb_char, m_bd, m_keyb);
      end
    end
  endtask

`ifdef KEYB_MAKE_BREAK_EN
  task automatic test_make_break();
    logic [7:0]  seq [5];
    logic [31:0] want [5];
    int bv0;
    seq[0] = 8'h1C; seq[1] = 8'hF0; seq[2] = 8'h1C; seq[3] = 8'hE0; seq[4] = 8'h75;
    want[0] = 32'h1C; want[1] = 32'h1C; want[2] = 32'h0; want[3] = 32'h0; want[4] = 32'hE075;
    // Clear any pending prefix left by earlier random bytes.
    reset_n = 1'b0;
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    model_reset();
    repeat (10) @(negedge clock);
    bv0 = bv_rise;
    for (int k = 0; k < 5; k++) begin
      send_frame(seq[k], 1'b0, 11, -1);
      model_accept(seq[k]);
      nvec++; if (keyb_char !== want[k] || keyb_char !== m_keyb) begin
        nerr++; $display("FAIL mb_keyb[%0d]: got %h want %h", k, keyb_char, want[k]);
      end
      nvec++; if (byte_data !== seq[k]) begin nerr++; $display("FAIL mb_bd[%0d]: got %h want %h", k, byte_data, seq[k]); end
    end
    nvec++; if (bv_rise - bv0 != 5) begin nerr++; $display("FAIL mb_bv_count: got %0d want 5", bv_rise - bv0); end
  endtask
`endif

  initial begin
    test_reset();
    test_default_frames();
    test_parity_error();
    test_timeout();
    test_glitch();
    test_reset_midframe();
    test_random_frames();
`ifdef KEYB_MAKE_BREAK_EN
    test_make_break();
`endif
    nvec++; if (both_hi != 0) begin nerr++; $display("FAIL strobe_overlap: got %0d want 0", both_hi); end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
